adia_phase_gen: RTL and testbench



---
 rtl/adia_phase_gen.sv | 116 +++++++++++
 tb/tb_adia_phase_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/adia_phase_gen.sv
// Quarter-phase power-clock sequencer and token tracker for cascaded adiabatic stages.
// Optional stall input is enabled by defining ADIA_PHASE_STALL_EN.
module adia_phase_gen #(
  parameter int NSTAGES = 7,
  parameter int QTICKS  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               in_valid,
`ifdef ADIA_PHASE_STALL_EN
  input  logic               stall,
`endif
  output logic               in_ready,
  output logic               out_valid,
  output logic               busy,
  output logic [0:NSTAGES-1] clkpos,
  output logic [0:NSTAGES-1] clkneg
);

  localparam int QW = (QTICKS > 1) ? $clog2(QTICKS) : 1;

  typedef enum logic [1:0] {OFF, RUN, DRAIN} state_t;

  state_t             r_state, w_stateNext;
  logic [QW-1:0]      r_qCnt, w_qCntNext;
  logic [1:0]         r_q, w_qNext;
  logic [NSTAGES-1:0] r_tok, w_tokNext;
  logic               w_stall, w_active, w_run, w_boundary, w_qWrap, w_accept;

`ifdef ADIA_PHASE_STALL_EN
  assign w_stall = stall && (r_state != OFF);
`else
  assign w_stall = 1'b0;
`endif

  assign w_active   = (r_state != OFF);
  assign w_run      = w_active && !w_stall;
  assign w_boundary = (r_qCnt == '0);
  assign w_qWrap    = (r_qCnt == QW'(QTICKS - 1));

  // Stage 0 enters EVAL when q becomes 1; that boundary is the only launch slot.
  assign in_ready  = (r_state == RUN) && !w_stall && (r_q == 2'd1) && w_boundary;
  assign w_accept  = in_ready && in_valid;
  assign out_valid = w_run && w_boundary && r_tok[NSTAGES-1];
  assign busy      = w_active;

  always_comb begin
    w_qCntNext = r_qCnt;
    w_qNext    = r_q;
    w_tokNext  = r_tok;
    if (w_run) begin
      w_qCntNext = w_qWrap ? '0 : r_qCnt + QW'(1);
      w_qNext    = w_qWrap ? r_q + 2'd1 : r_q;
      if (w_boundary) begin
        w_tokNext[0] = w_accept;
        for (int i = 1; i < NSTAGES; i++) begin
          w_tokNext[i] = r_tok[i-1];
        end
      end
    end
  end

  // DRAIN exits when the coming cycle is the q=0 boundary with nothing in flight,
  // so OFF is entered exactly on that boundary.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      OFF:   if (en) w_stateNext = RUN;
      RUN:   if (!w_stall && !en) w_stateNext = DRAIN;
      DRAIN: begin
        if (!w_stall) begin
          if (en) begin
            w_stateNext = RUN;
          end else if (w_qNext == 2'd0 && w_qCntNext == '0 && w_tokNext == '0) begin
            w_stateNext = OFF;
          end
        end
      end
      default: w_stateNext = OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= OFF;
      r_qCnt  <= '0;
      r_q     <= 2'd0;
      r_tok   <= '0;
    end else begin
      r_state <= w_stateNext;
      if (w_stateNext == OFF) begin
        r_qCnt <= '0;
        r_q    <= 2'd0;
        r_tok  <= '0;
      end else begin
        r_qCnt <= w_qCntNext;
        r_q    <= w_qNext;
        r_tok  <= w_tokNext;
      end
    end
  end

  // Stage i lags stage 0 by i quarters; EVAL and HOLD drive the positive rail.
  always_comb begin
    logic [1:0] ph;
    clkpos = '0;
    for (int i = 0; i < NSTAGES; i++) begin
      ph        = r_q - 2'(i);
      clkpos[i] = w_active && ((ph == 2'd1) || (ph == 2'd2));
    end
  end

  assign clkneg = ~clkpos;

endmodule

// File: tb/tb_adia_phase_gen.sv
// Scoreboard bench for adia_phase_gen: default instance (7 stages, 4 ticks) and a 3x1 instance.
// Stall scenario is compiled only when ADIA_PHASE_STALL_EN is defined.
module tb_adia_phase_gen;

  localparam int NA = 7, QA = 4;
  localparam int NB = 3, QB = 1;

  logic clk = 1'b0;
  logic rst_n, en, inValid, enB, inValidB, stall;
  logic inReadyA, outValidA, busyA, inReadyB, outValidB, busyB;
  logic [0:NA-1] clkposA, clknegA;
  logic [0:NB-1] clkposB, clknegB;

  int cyc = 0;
  int nChecks = 0;
  int nFails = 0;
  int sbA[$];
  int sbB[$];

  adia_phase_gen #(.NSTAGES(NA), .QTICKS(QA)) dutA (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(inValid),
`ifdef ADIA_PHASE_STALL_EN
    .stall(stall),
`endif
    .in_ready(inReadyA), .out_valid(outValidA), .busy(busyA),
    .clkpos(clkposA), .clkneg(clknegA)
  );

  adia_phase_gen #(.NSTAGES(NB), .QTICKS(QB)) dutB (
    .clk(clk), .rst_n(rst_n), .en(enB), .in_valid(inValidB),
`ifdef ADIA_PHASE_STALL_EN
    .stall(1'b0),
`endif
    .in_ready(inReadyB), .out_valid(outValidB), .busy(busyB),
    .clkpos(clkposB), .clkneg(clknegB)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic enV, input logic validV);
    en      = enV;
    inValid = validV;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0);
    enB = 1'b0;
    inValidB = 1'b0;
    stall = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic startRun(output int t);
    en = 1'b1;
    tick();
    t = cyc;
  endtask

  // Acceptances push their due cycle; stalled cycles push every pending due cycle out by one.
  always @(negedge clk) begin
    int e;
    if (!rst_n) begin
      sbA.delete();
      sbB.delete();
    end else begin
      if (stall && busyA) begin
        foreach (sbA[j]) sbA[j] = sbA[j] + 1;
      end
      if (inValid && inReadyA) sbA.push_back(cyc + NA * QA);
      if (outValidA) begin
        if (sbA.size() == 0) checkOutput("ovA_unexpected", 1, 0);
        else begin
          e = sbA.pop_front();
          checkOutput("ovA_cycle", cyc, e);
        end
      end
      if (inValidB && inReadyB) sbB.push_back(cyc + NB * QB);
      if (outValidB) begin
        if (sbB.size() == 0) checkOutput("ovB_unexpected", 1, 0);
        else begin
          e = sbB.pop_front();
          checkOutput("ovB_cycle", cyc, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t;
    int w;
    logic e0, e1, e6;

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0);
    enB = 1'b0;
    inValidB = 1'b0;
    stall = 1'b0;
    repeat (3) tick();
    #2;
    checkOutput("rst_inReady", inReadyA, 0);
    checkOutput("rst_outValid", outValidA, 0);
    checkOutput("rst_busy", busyA, 0);
    checkOutput("rst_clkpos", clkposA, 0);
    checkOutput("rst_clkneg", clknegA, 7'h7F);
    rst_n = 1'b1;
    tick();

    $display("[TB] phase pattern, no tokens");
    startRun(t);
    for (int k = 0; k < 24; k++) begin
      #2;
      e0 = (k >= 4 && k <= 11) || (k >= 20);
      e1 = (k >= 8 && k <= 15);
      e6 = (k <= 3) || (k >= 12 && k <= 19);
      checkOutput("pat_pos0", clkposA[0], e0);
      checkOutput("pat_pos1", clkposA[1], e1);
      checkOutput("pat_pos6", clkposA[6], e6);
      checkOutput("pat_neg0", clknegA[0], !e0);
      checkOutput("pat_neg6", clknegA[6], !e6);
      checkOutput("pat_busy", busyA, 1);
      tick();
    end

    $display("[TB] continuous tokens");
    doReset();
    applyStimulus(1'b0, 1'b1);
    startRun(t);
    for (int k = 0; k <= 66; k++) begin
      if (k == 37) inValid = 1'b0;
      #2;
      if (k <= 40) checkOutput("tok_inReady", inReadyA, (k == 4 || k == 20 || k == 36));
      if (k == 32) begin
        checkOutput("tok_hold6", clkposA[6], 1);
        checkOutput("tok_vec32", clkposA, 7'b0011001);
      end
      tick();
    end
    checkOutput("tok_sbEmpty", sbA.size(), 0);

    $display("[TB] reset with token in flight");
    inValid = 1'b1;
    for (w = 0; w < 40 && sbA.size() == 0; w++) tick();
    checkOutput("rst_tokLaunched", (sbA.size() != 0), 1);
    inValid = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    #2;
    checkOutput("midrst_clkpos", clkposA, 0);
    checkOutput("midrst_clkneg", clknegA, 7'h7F);
    checkOutput("midrst_busy", busyA, 0);
    checkOutput("midrst_outValid", outValidA, 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 60; k++) begin
      #2;
      checkOutput("midrst_noOut", outValidA, 0);
      tick();
    end

    $display("[TB] drain to off");
    doReset();
    applyStimulus(1'b0, 1'b1);
    startRun(t);
    for (int k = 0; k <= 56; k++) begin
      if (k == 10) en = 1'b0;
      #2;
      checkOutput("drn_inReady", inReadyA, (k == 4));
      checkOutput("drn_busy", busyA, (k < 48));
      if (k >= 48) checkOutput("drn_offClk", clkposA, 0);
      tick();
    end
    checkOutput("drn_sbEmpty", sbA.size(), 0);

    $display("[TB] 3 stages, 1 tick per quarter");
    doReset();
    inValidB = 1'b1;
    enB = 1'b1;
    tick();
    for (int k = 0; k < 40; k++) begin
      #2;
      checkOutput("b_inReady", inReadyB, (k % 4 == 1));
      tick();
    end
    inValidB = 1'b0;
    repeat (8) tick();
    checkOutput("b_sbEmpty", sbB.size(), 0);

`ifdef ADIA_PHASE_STALL_EN
    $display("[TB] stall delays result");
    doReset();
    applyStimulus(1'b0, 1'b1);
    startRun(t);
    for (int k = 0; k <= 45; k++) begin
      if (k == 5) inValid = 1'b0;
      stall = (k >= 10 && k <= 14);
      #2;
      if (k >= 10 && k <= 15) checkOutput("stl_frozen", clkposA, 7'b1100110);
      checkOutput("stl_outValid", outValidA, (k == 37));
      tick();
    end
    stall = 1'b0;
    checkOutput("stl_sbEmpty", sbA.size(), 0);
`endif

    doReset();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
